// File: rtl/bbox_pkg.sv
// bbox_pkg: shared definitions for the motion-pipeline bounding-box stage.
//   LABEL_WIDTH / X_WIDTH / Y_WIDTH : default label and coordinate widths
//   MIN_W / MIN_H                   : default size filter (inclusive width/height)
//   bbox_t                          : one emitted box (label plus inclusive extents)
//   state_e                         : accumulator sequencing states
package bbox_pkg;

    localparam int unsigned LABEL_WIDTH = 8;
    localparam int unsigned X_WIDTH     = 11;
    localparam int unsigned Y_WIDTH     = 10;
    localparam int unsigned MIN_W       = 2;
    localparam int unsigned MIN_H       = 2;

    typedef struct packed {
        logic [LABEL_WIDTH-1:0] label;
        logic [X_WIDTH-1:0]     min_x;
        logic [X_WIDTH-1:0]     max_x;
        logic [Y_WIDTH-1:0]     min_y;
        logic [Y_WIDTH-1:0]     max_y;
    } bbox_t;

    typedef enum logic [0:0] {
        ACCUM,
        FLUSH
    } state_e;

endpackage

// File: rtl/bbox_accumulator_if.sv
// bbox_accumulator_if: pixel-in and box-out streams of the bounding-box accumulator.
//   Pixel stream : enable, pix_valid, pix_ready, pix_label, pix_x, pix_y, last_in_frame
//   Box stream   : box_valid, box_ready, box_label, box_min_x/max_x, box_min_y/max_y
//   Status       : box_count, frame_done
// Modports:
//   master : the environment (produces pixels, consumes boxes)
//   slave  : the accumulator
interface bbox_accumulator_if #(
    parameter int unsigned LABEL_WIDTH = bbox_pkg::LABEL_WIDTH,
    parameter int unsigned X_WIDTH     = bbox_pkg::X_WIDTH,
    parameter int unsigned Y_WIDTH     = bbox_pkg::Y_WIDTH
);

    logic                   enable;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [LABEL_WIDTH-1:0] pix_label;
    logic [X_WIDTH-1:0]     pix_x;
    logic [Y_WIDTH-1:0]     pix_y;
    logic                   last_in_frame;

    logic                   box_valid;
    logic                   box_ready;
    logic [LABEL_WIDTH-1:0] box_label;
    logic [X_WIDTH-1:0]     box_min_x;
    logic [X_WIDTH-1:0]     box_max_x;
    logic [Y_WIDTH-1:0]     box_min_y;
    logic [Y_WIDTH-1:0]     box_max_y;
    logic [LABEL_WIDTH-1:0] box_count;
    logic                   frame_done;

    modport master (
        output enable, pix_valid, pix_label, pix_x, pix_y, last_in_frame, box_ready,
        input  pix_ready, box_valid, box_label, box_min_x, box_max_x, box_min_y, box_max_y,
        input  box_count, frame_done
    );

    modport slave (
        input  enable, pix_valid, pix_label, pix_x, pix_y, last_in_frame, box_ready,
        output pix_ready, box_valid, box_label, box_min_x, box_max_x, box_min_y, box_max_y,
        output box_count, frame_done
    );

endinterface

// File: rtl/bbox_table.sv
// bbox_table: per-label bounding-box store.
//   clk, rst        : clock, synchronous active-high reset (clears all valid bits)
//   upd_en          : accepted pixel beat; label 0 never writes
//   upd_label/x/y   : beat to fold into the entry (combinational read, single-cycle write)
//   scan_idx        : entry being examined by the flush sequencer
//   scan_valid/...  : combinational read of that entry
//   clr_en          : invalidate the entry at scan_idx
module bbox_table #(
    parameter int unsigned LABEL_WIDTH = bbox_pkg::LABEL_WIDTH,
    parameter int unsigned X_WIDTH     = bbox_pkg::X_WIDTH,
    parameter int unsigned Y_WIDTH     = bbox_pkg::Y_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   upd_en,
    input  logic [LABEL_WIDTH-1:0] upd_label,
    input  logic [X_WIDTH-1:0]     upd_x,
    input  logic [Y_WIDTH-1:0]     upd_y,

    input  logic [LABEL_WIDTH-1:0] scan_idx,
    output logic                   scan_valid,
    output logic [X_WIDTH-1:0]     scan_min_x,
    output logic [X_WIDTH-1:0]     scan_max_x,
    output logic [Y_WIDTH-1:0]     scan_min_y,
    output logic [Y_WIDTH-1:0]     scan_max_y,
    input  logic                   clr_en
);

    localparam int unsigned Entries = 2 ** LABEL_WIDTH;

    // Only the valid bits are reset; extents are don't-care while invalid.
    logic [Entries-1:0] valid_q;
    logic [X_WIDTH-1:0] min_x_q [Entries];
    logic [X_WIDTH-1:0] max_x_q [Entries];
    logic [Y_WIDTH-1:0] min_y_q [Entries];
    logic [Y_WIDTH-1:0] max_y_q [Entries];

    logic               wr_en;
    logic               cur_valid;
    logic [X_WIDTH-1:0] nxt_min_x;
    logic [X_WIDTH-1:0] nxt_max_x;
    logic [Y_WIDTH-1:0] nxt_min_y;
    logic [Y_WIDTH-1:0] nxt_max_y;

    // Read-modify-write in one cycle: a beat always sees the previous beat's result.
    always_comb begin
        wr_en     = upd_en && (upd_label != '0);
        cur_valid = valid_q[upd_label];
        nxt_min_x = (!cur_valid || (upd_x < min_x_q[upd_label])) ? upd_x : min_x_q[upd_label];
        nxt_max_x = (!cur_valid || (upd_x > max_x_q[upd_label])) ? upd_x : max_x_q[upd_label];
        nxt_min_y = (!cur_valid || (upd_y < min_y_q[upd_label])) ? upd_y : min_y_q[upd_label];
        nxt_max_y = (!cur_valid || (upd_y > max_y_q[upd_label])) ? upd_y : max_y_q[upd_label];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[upd_label] <= 1'b1;
            end
            if (clr_en) begin
                valid_q[scan_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            min_x_q[upd_label] <= nxt_min_x;
            max_x_q[upd_label] <= nxt_max_x;
            min_y_q[upd_label] <= nxt_min_y;
            max_y_q[upd_label] <= nxt_max_y;
        end
    end

    always_comb begin
        scan_valid = valid_q[scan_idx];
        scan_min_x = min_x_q[scan_idx];
        scan_max_x = max_x_q[scan_idx];
        scan_min_y = min_y_q[scan_idx];
        scan_max_y = max_y_q[scan_idx];
    end

endmodule

// File: rtl/bbox_accumulator.sv
// bbox_accumulator: accumulates per-label min/max X/Y from resolved labels, then at end
// of frame scans labels 1..2^LABEL_WIDTH-1 and streams every box meeting MIN_W x MIN_H.
//   clk, rst : clock, synchronous active-high reset (drops any pending box, clears table)
//   bus      : bbox_accumulator_if.slave
//              pixel stream in, registered box stream out, box_count, frame_done pulse
module bbox_accumulator #(
    parameter int unsigned LABEL_WIDTH = bbox_pkg::LABEL_WIDTH,
    parameter int unsigned X_WIDTH     = bbox_pkg::X_WIDTH,
    parameter int unsigned Y_WIDTH     = bbox_pkg::Y_WIDTH,
    parameter int unsigned MIN_W       = bbox_pkg::MIN_W,
    parameter int unsigned MIN_H       = bbox_pkg::MIN_H
) (
    input logic               clk,
    input logic               rst,
    bbox_accumulator_if.slave bus
);

    import bbox_pkg::*;

    state_e                 state_q, state_d;

    logic [LABEL_WIDTH-1:0] scan_q, scan_d;
    logic                   box_valid_q, box_valid_d;
    logic [LABEL_WIDTH-1:0] box_label_q, box_label_d;
    logic [X_WIDTH-1:0]     box_min_x_q, box_min_x_d;
    logic [X_WIDTH-1:0]     box_max_x_q, box_max_x_d;
    logic [Y_WIDTH-1:0]     box_min_y_q, box_min_y_d;
    logic [Y_WIDTH-1:0]     box_max_y_q, box_max_y_d;
    logic [LABEL_WIDTH-1:0] box_count_q, box_count_d;
    logic                   frame_done_q, frame_done_d;

    logic                   pix_ready;
    logic                   accept;
    logic                   last_accept;
    logic                   clr_en;
    logic                   retire;

    logic                   scan_valid;
    logic [X_WIDTH-1:0]     scan_min_x;
    logic [X_WIDTH-1:0]     scan_max_x;
    logic [Y_WIDTH-1:0]     scan_min_y;
    logic [Y_WIDTH-1:0]     scan_max_y;
    logic [X_WIDTH:0]       box_w;
    logic [Y_WIDTH:0]       box_h;
    logic                   size_ok;

    assign accept      = bus.pix_valid && pix_ready && bus.enable;
    assign last_accept = accept && bus.last_in_frame;

    bbox_table #(
        .LABEL_WIDTH (LABEL_WIDTH),
        .X_WIDTH     (X_WIDTH),
        .Y_WIDTH     (Y_WIDTH)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .upd_en     (accept),
        .upd_label  (bus.pix_label),
        .upd_x      (bus.pix_x),
        .upd_y      (bus.pix_y),
        .scan_idx   (scan_q),
        .scan_valid (scan_valid),
        .scan_min_x (scan_min_x),
        .scan_max_x (scan_max_x),
        .scan_min_y (scan_min_y),
        .scan_max_y (scan_max_y),
        .clr_en     (clr_en)
    );

    // One extra bit so a full-range extent cannot wrap.
    always_comb begin
        box_w   = {1'b0, scan_max_x} - {1'b0, scan_min_x} + (X_WIDTH + 1)'(1);
        box_h   = {1'b0, scan_max_y} - {1'b0, scan_min_y} + (Y_WIDTH + 1)'(1);
        size_ok = (box_w >= (X_WIDTH + 1)'(MIN_W)) && (box_h >= (Y_WIDTH + 1)'(MIN_H));
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. FLUSH lingers for the frame_done cycle so pix_ready stays low through it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: if (last_accept) state_d = FLUSH;
            FLUSH: if (frame_done_q) state_d = ACCUM;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        pix_ready = (state_q == ACCUM);
    end

    // Scan sequencing. A passing entry takes one cycle to load the box register and
    // retires on the handshake; everything else retires in its own cycle.
    always_comb begin
        scan_d       = scan_q;
        box_valid_d  = box_valid_q;
        box_label_d  = box_label_q;
        box_min_x_d  = box_min_x_q;
        box_max_x_d  = box_max_x_q;
        box_min_y_d  = box_min_y_q;
        box_max_y_d  = box_max_y_q;
        box_count_d  = box_count_q;
        frame_done_d = 1'b0;
        clr_en       = 1'b0;
        retire       = 1'b0;

        if (state_q == ACCUM) begin
            if (last_accept) begin
                scan_d      = LABEL_WIDTH'(1);
                box_count_d = '0;
            end
        end else if (!frame_done_q) begin
            if (box_valid_q) begin
                if (bus.box_ready) begin
                    clr_en      = 1'b1;
                    box_valid_d = 1'b0;
                    retire      = 1'b1;
                    if (box_count_q != '1) begin
                        box_count_d = box_count_q + LABEL_WIDTH'(1);
                    end
                end
            end else if (!scan_valid) begin
                retire = 1'b1;
            end else if (!size_ok) begin
                clr_en = 1'b1;
                retire = 1'b1;
            end else begin
                box_valid_d = 1'b1;
                box_label_d = scan_q;
                box_min_x_d = scan_min_x;
                box_max_x_d = scan_max_x;
                box_min_y_d = scan_min_y;
                box_max_y_d = scan_max_y;
            end
        end

        if (retire) begin
            if (scan_q == '1) begin
                frame_done_d = 1'b1;
            end else begin
                scan_d = scan_q + LABEL_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q       <= LABEL_WIDTH'(1);
            box_valid_q  <= 1'b0;
            box_label_q  <= '0;
            box_min_x_q  <= '0;
            box_max_x_q  <= '0;
            box_min_y_q  <= '0;
            box_max_y_q  <= '0;
            box_count_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            scan_q       <= scan_d;
            box_valid_q  <= box_valid_d;
            box_label_q  <= box_label_d;
            box_min_x_q  <= box_min_x_d;
            box_max_x_q  <= box_max_x_d;
            box_min_y_q  <= box_min_y_d;
            box_max_y_q  <= box_max_y_d;
            box_count_q  <= box_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pix_ready  = pix_ready;
    assign bus.box_valid  = box_valid_q;
    assign bus.box_label  = box_label_q;
    assign bus.box_min_x  = box_min_x_q;
    assign bus.box_max_x  = box_max_x_q;
    assign bus.box_min_y  = box_min_y_q;
    assign bus.box_max_y  = box_max_y_q;
    assign bus.box_count  = box_count_q;
    assign bus.frame_done = frame_done_q;

endmodule
